program_loader: RTL and testbench

- Upstream feeder of the control unit's programmer interface.
- Accepts a program as a stream of 4-bit words over a valid/ready handshake from board-level logic (switches/host bridge).
- Requests programming mode, writes each word to sequential memory addresses through the control unit, then releases the CPU to run from address 0.
- Synchronises and edge-detects the asynchronous start button.

---
 rtl/program_loader.sv | 123 ++++++++++++
 tb/tb_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams a program into memory through the control unit's programmer interface.
// A synchronised start button begins a load. Words from a valid/ready stream are written to sequential addresses.
module program_loader #(
  parameter int unsigned REGISTER_WIDTH       = 4,
  parameter int unsigned MEMORY_ADDRESS_WIDTH = 4,
  parameter int unsigned PROG_LENGTH          = 16
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            start_i,
  input  logic                            ld_valid_i,
  input  logic [REGISTER_WIDTH-1:0]       ld_data_i,
  input  logic                            ld_last_i,
  output logic                            ld_ready_o,
  input  logic                            p_active_i,
  output logic                            p_programm_o,
  output logic [REGISTER_WIDTH-1:0]       p_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] p_address_o,
  output logic                            p_write_en_mem_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o,
  output logic [MEMORY_ADDRESS_WIDTH:0]   word_count_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LOAD,
    S_WRITE,
    S_RELEASE,
    S_ABORT
  } state_t;

  localparam logic [MEMORY_ADDRESS_WIDTH:0]   PROG_LEN_W = (MEMORY_ADDRESS_WIDTH+1)'(PROG_LENGTH);
  localparam logic [MEMORY_ADDRESS_WIDTH:0]   WC_ONE     = (MEMORY_ADDRESS_WIDTH+1)'(1);
  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ONE   = MEMORY_ADDRESS_WIDTH'(1);

  state_t                          state_q;
  logic [2:0]                      start_sync_q;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q;
  logic                            last_q;
  logic                            start_pulse;
  logic [MEMORY_ADDRESS_WIDTH:0]   wc_next;

  // Bits [1:0] are the synchroniser; bit 2 is the previous synchronised level.
  assign start_pulse = start_sync_q[1] & ~start_sync_q[2];
  assign ld_ready_o  = (state_q == S_LOAD) & p_active_i;
  assign busy_o      = (state_q != S_IDLE);

  always_comb begin
    wc_next = word_count_o + WC_ONE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q          <= S_IDLE;
      start_sync_q     <= '0;
      addr_q           <= '0;
      last_q           <= 1'b0;
      p_programm_o     <= 1'b0;
      p_data_o         <= '0;
      p_address_o      <= '0;
      p_write_en_mem_o <= 1'b0;
      done_o           <= 1'b0;
      error_o          <= 1'b0;
      word_count_o     <= '0;
    end else begin
      start_sync_q     <= {start_sync_q[1:0], start_i};
      p_write_en_mem_o <= 1'b0;
      done_o           <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_pulse) begin
            addr_q       <= '0;
            word_count_o <= '0;
            error_o      <= 1'b0;
            p_programm_o <= 1'b1;
            state_q      <= S_REQ;
          end
        end
        S_REQ: begin
          if (p_active_i) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (!p_active_i) begin
            p_programm_o <= 1'b0;
            error_o      <= 1'b1;
            state_q      <= S_ABORT;
          end else if (ld_valid_i) begin
            // The stored word doubles as the held memory-data output.
            p_data_o         <= ld_data_i;
            p_address_o      <= addr_q;
            last_q           <= ld_last_i;
            p_write_en_mem_o <= 1'b1;
            state_q          <= S_WRITE;
          end
        end
        S_WRITE: begin
          addr_q       <= addr_q + ADDR_ONE;
          word_count_o <= wc_next;
          if (last_q || (wc_next == PROG_LEN_W)) begin
            p_programm_o <= 1'b0;
            state_q      <= S_RELEASE;
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_RELEASE: begin
          if (!p_active_i) begin
            done_o  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        S_ABORT: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table of load scenarios plus hand-written glitch/reset sequences.
// Expected memory writes are queued as words are offered and matched against write strobes.
module tb_program_loader;

  localparam int unsigned RW = 4;
  localparam int unsigned AW = 4;
  localparam int unsigned PL = 16;

  logic          clk_i      = 1'b0;
  logic          reset_i    = 1'b1;
  logic          start_i    = 1'b0;
  logic          ld_valid_i = 1'b0;
  logic [RW-1:0] ld_data_i  = '0;
  logic          ld_last_i  = 1'b0;
  logic          p_active_i = 1'b0;
  logic          ld_ready_o;
  logic          p_programm_o;
  logic [RW-1:0] p_data_o;
  logic [AW-1:0] p_address_o;
  logic          p_write_en_mem_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [AW:0]   word_count_o;

  logic          cu_kill = 1'b0;
  int            n_chk   = 0;
  int            n_pass  = 0;
  int            done_cnt = 0;
  logic [7:0]    sb[$];
  logic [7:0]    sb_exp;

  typedef struct {
    int unsigned      n;
    int               last_idx;
    int unsigned      max_gap;
    bit               abort;
    logic [15:0][3:0] words;
    int unsigned      exp_count;
    int unsigned      exp_done;
    bit               exp_err;
  } scn_t;

  scn_t tbl[6];

  program_loader #(
    .REGISTER_WIDTH      (RW),
    .MEMORY_ADDRESS_WIDTH(AW),
    .PROG_LENGTH         (PL)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .ld_valid_i      (ld_valid_i),
    .ld_data_i       (ld_data_i),
    .ld_last_i       (ld_last_i),
    .ld_ready_o      (ld_ready_o),
    .p_active_i      (p_active_i),
    .p_programm_o    (p_programm_o),
    .p_data_o        (p_data_o),
    .p_address_o     (p_address_o),
    .p_write_en_mem_o(p_write_en_mem_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .word_count_o    (word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Control unit model: enters/leaves programming one cycle after the request.
  always @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) p_active_i <= 1'b0;
    else          p_active_i <= p_programm_o & ~cu_kill;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk_i) begin
    if (reset_i) begin
      if (p_write_en_mem_o) begin
        chk("ready_low_in_write", {31'd0, ld_ready_o}, 32'd0);
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", p_address_o, p_data_o);
        end else begin
          sb_exp = sb.pop_front();
          chk("write_addr_data", {24'd0, p_address_o, p_data_o}, {24'd0, sb_exp});
        end
      end
      if (done_o) begin
        done_cnt++;
        chk("prog_low_at_done", {31'd0, p_programm_o}, 32'd0);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_programm"}, {31'd0, p_programm_o}, 32'd0);
    chk({tag, "_wen"},      {31'd0, p_write_en_mem_o}, 32'd0);
    chk({tag, "_data"},     {28'd0, p_data_o}, 32'd0);
    chk({tag, "_addr"},     {28'd0, p_address_o}, 32'd0);
    chk({tag, "_busy"},     {31'd0, busy_o}, 32'd0);
    chk({tag, "_done"},     {31'd0, done_o}, 32'd0);
    chk({tag, "_error"},    {31'd0, error_o}, 32'd0);
    chk({tag, "_wc"},       {27'd0, word_count_o}, 32'd0);
    chk({tag, "_ready"},    {31'd0, ld_ready_o}, 32'd0);
  endtask

  // Must be called #1 after a rising edge with start_i low for several cycles.
  task automatic do_start();
    int unsigned to;
    to = 0;
    start_i = 1'b1;
    while (!busy_o && to < 20) begin
      @(negedge clk_i);
      to++;
    end
    chk("start_latency", to, 32'd4);
    chk("start_busy", {31'd0, busy_o}, 32'd1);
    chk("start_err_clr", {31'd0, error_o}, 32'd0);
    chk("start_wc_clr", {27'd0, word_count_o}, 32'd0);
    start_i = 1'b0;
  endtask

  task automatic send_word(input int idx, input logic [3:0] d, input bit last, input int unsigned gap);
    int unsigned to;
    to = 0;
    if (gap > 0) begin
      ld_valid_i = 1'b0;
      repeat (gap) @(posedge clk_i);
      #1;
    end
    ld_data_i  = d;
    ld_last_i  = last;
    ld_valid_i = 1'b1;
    sb.push_back({4'(idx), d});
    do begin
      @(negedge clk_i);
      to++;
    end while (!ld_ready_o && to < 60);
    if (!ld_ready_o) begin
      n_chk++;
      $display("FAIL accept_timeout: got ready 0 expected 1 for word %0d", idx);
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned to;
    to = 0;
    while (busy_o && to < 300) begin
      @(negedge clk_i);
      to++;
    end
    chk("idle_reached", {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    // Scenario table: ramp full load, early last, gaps, abort, single word, gapped full load.
    tbl[0] = '{n:16, last_idx:-1, max_gap:0, abort:1'b0, words:'0, exp_count:16, exp_done:1, exp_err:1'b0};
    tbl[1] = '{n:3,  last_idx:2,  max_gap:0, abort:1'b0, words:'0, exp_count:3,  exp_done:1, exp_err:1'b0};
    tbl[2] = '{n:6,  last_idx:5,  max_gap:5, abort:1'b0, words:'0, exp_count:6,  exp_done:1, exp_err:1'b0};
    tbl[3] = '{n:2,  last_idx:-1, max_gap:0, abort:1'b1, words:'0, exp_count:2,  exp_done:0, exp_err:1'b1};
    tbl[4] = '{n:1,  last_idx:0,  max_gap:2, abort:1'b0, words:'0, exp_count:1,  exp_done:1, exp_err:1'b0};
    tbl[5] = '{n:16, last_idx:15, max_gap:3, abort:1'b0, words:'0, exp_count:16, exp_done:1, exp_err:1'b0};
    for (int i = 0; i < 16; i++) begin
      tbl[0].words[i] = 4'(i);
      tbl[2].words[i] = 4'($urandom);
      tbl[3].words[i] = 4'(i + 5);
      tbl[4].words[i] = 4'($urandom);
      tbl[5].words[i] = 4'($urandom);
    end
    tbl[1].words[0] = 4'h9;
    tbl[1].words[1] = 4'h3;
    tbl[1].words[2] = 4'hE;

    // Reset with the start button toggling.
    #2 reset_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i);
      #1 start_i = ~start_i;
    end
    start_i = 1'b0;
    @(negedge clk_i);
    check_all_zero("reset");
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (10) @(posedge clk_i);
    #1;
    chk("idle_hold_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_hold_prog", {31'd0, p_programm_o}, 32'd0);

    for (int s = 0; s < 6; s++) begin
      done_cnt = 0;
      do_start();
      for (int i = 0; i < int'(tbl[s].n); i++)
        send_word(i, tbl[s].words[i], (i == tbl[s].last_idx),
                  (tbl[s].max_gap > 0) ? $urandom_range(0, tbl[s].max_gap) : 0);
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
      if (tbl[s].abort) cu_kill = 1'b1;
      wait_idle();
      cu_kill = 1'b0;
      chk($sformatf("s%0d_word_count", s), {27'd0, word_count_o}, tbl[s].exp_count);
      chk($sformatf("s%0d_error", s), {31'd0, error_o}, {31'd0, tbl[s].exp_err});
      chk($sformatf("s%0d_done_pulses", s), done_cnt, tbl[s].exp_done);
      chk($sformatf("s%0d_pending_writes", s), sb.size(), 32'd0);
      repeat (4) @(posedge clk_i);
      #1;
    end

    // Start glitch during a load is ignored; reset during WRITE clears everything at once.
    done_cnt = 0;
    do_start();
    send_word(0, 4'hA, 1'b0, 0);
    send_word(1, 4'h5, 1'b0, 0);
    ld_valid_i = 1'b0;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
    chk("glitch_wc", {27'd0, word_count_o}, 32'd2);
    chk("glitch_busy", {31'd0, busy_o}, 32'd1);
    chk("glitch_ready", {31'd0, ld_ready_o}, 32'd1);
    send_word(2, 4'hC, 1'b0, 0);
    ld_valid_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("pre_reset_wen", {31'd0, p_write_en_mem_o}, 32'd1);
    reset_i = 1'b0;
    #1;
    check_all_zero("async_reset");
    chk("reset_pending_writes", sb.size(), 32'd0);
    chk("reset_done_pulses", done_cnt, 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    repeat (3) @(posedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
